csense_spi_master: RTL and testbench
====================================

# csense_spi_master

SPI master that drives the current-sense ADC's command path: CS_n, SCLK and SDI. The return line, SDO, is read back by software through a separate input port. An Avalon-MM slave accepts a command word, serialises it MSB-first in SPI mode 0, and reports completion through a status register and an interrupt. It sits on the same Qsys bus as the other board-control peripherals.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range ≥1.
- FRAME_BITS, 16: bits per frame; legal range 1..32. Frame is writedata[FRAME_BITS-1:0].

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data.
- read  in  1  Avalon read strobe.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt = done & irq_en.
- csense_cs_n  out  1  ADC chip select, active low.
- csense_sclk  out  1  SPI clock; idles low.
- csense_sdi  out  1  serial data to the ADC.
- csense_sdo  in  1  serial data from the ADC; used only when capture is compiled in.

## Operation
- Register map:
  - 0 TXDATA (W): a write while idle starts a frame.
  - 1 STATUS (R/W1C): bit0 busy (read-only), bit1 done (sticky), bit2 overrun (sticky).
  - 2 RXDATA (R).
  - 3 CONTROL (R/W): bit0 irq_en.
  - Unused bits read 0.
- readdata is updated every clk cycle from address. Read latency is 1 cycle; no waitrequest.
- FSM states: IDLE → SETUP → SCLK_HI ⇄ SCLK_LO → GAP → IDLE.
  - IDLE: cs_n=1, sclk=0, sdi=0.
  - TXDATA write in IDLE: load the shift register; next state SETUP. cs_n=0, sdi=bit FRAME_BITS-1, busy=1.
  - SETUP: lasts CLK_DIV cycles, then enter SCLK_HI.
  - SCLK_HI: sclk=1 for CLK_DIV cycles.
  - SCLK_LO: sclk=0 for CLK_DIV cycles. Entering SCLK_LO shifts sdi to the next bit.
  - Bit counter: after FRAME_BITS high phases, the final SCLK_LO is followed by GAP.
  - GAP: cs_n=1, sdi=0 for CLK_DIV cycles. Then IDLE; busy=0, done=1.
- TXDATA write while busy: ignored; sets overrun. The frame in progress is unaffected.
- W1C semantics: writing 1 to STATUS bit1 or bit2 clears that bit. If a set and a clear land in the same cycle, the set wins.
- Reset at any point, including mid-frame: all outputs return to their idle values asynchronously. State, registers, done, overrun and irq_en are cleared.

## Timing
- Reset values: csense_cs_n=1, csense_sclk=0, csense_sdi=0, readdata=0, irq=0.
- Reference point: the write is accepted at edge 0. At cycle 1, cs_n falls and busy=1.
- First SCLK rising edge occurs at cycle 1+CLK_DIV.
- cs_n rises at cycle 1+CLK_DIV+2·CLK_DIV·FRAME_BITS.
- busy falls and done rises CLK_DIV cycles after that. The irq follows done in the same cycle.
- Defaults (CLK_DIV=4, FRAME_BITS=16): cs_n low for cycles 1..132; idle at cycle 137.
- sdi is stable for ≥CLK_DIV cycles around every SCLK rising edge, satisfying mode-0 setup and hold.
- A new frame can be accepted in the cycle after busy falls.

## Configuration
- CSENSE_SDO_CAPTURE_EN
  - Defined: csense_sdo passes through a 2-flop synchroniser and is sampled on the last clk cycle of each SCLK_HI. It is shifted MSB-first into a receive register; RXDATA latches that register when done is set.
  - Undefined: csense_sdo is unused, the synchroniser and receive register are absent, and RXDATA reads 0.

## Structure
- Package csense_spi_pkg contains:
  - FSM state enum.
  - Register address constants (TXDATA, STATUS, RXDATA, CONTROL).
  - STATUS and CONTROL bit indices.
- One sub-module, csense_spi_clkgen: a CLK_DIV phase counter producing a phase_end tick, enabled only while not IDLE. The FSM advances only on phase_end.

## Test plan
- Reset mid-frame: assert reset_n at cycle 50 of a frame → cs_n=1, sclk=0, sdi=0 immediately. Both busy and done read 0 after release.
- Basic frame, defaults: write 0xA5C3 → 16 SCLK rising edges, sdi sampled at the rises = 1010010111000011. cs_n low for cycles 1..132; done=1 and irq=1 (irq_en=1) at cycle 137.
- Overrun: write 0x1234 at cycle 10 of an active frame → transmitted bits unchanged, STATUS=0x5. Writing 0x6 to STATUS, then reading, gives 0x1 while busy.
- W1C race: write 0x2 to STATUS in the same cycle done sets → done remains 1.
- Parameter corner, CLK_DIV=1, FRAME_BITS=1: write 0x1 → sclk high for exactly 1 cycle, sdi=1; idle at cycle 5.
- Capture (macro defined): ADC model returns 0x0F0F on sdo during a 0xFFFF frame → RXDATA=0x00000F0F when done rises. Without the macro, RXDATA=0.

Source files
------------

// File: rtl/csense_spi_pkg.sv
// Shared types and constants for the current-sense ADC SPI master.
package csense_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSclkHi,
    StSclkLo,
    StGap
  } state_e;

  // Register addresses
  localparam logic [1:0] AddrTxdata  = 2'd0;
  localparam logic [1:0] AddrStatus  = 2'd1;
  localparam logic [1:0] AddrRxdata  = 2'd2;
  localparam logic [1:0] AddrControl = 2'd3;

  // STATUS / CONTROL bit positions
  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusDoneBit    = 1;
  localparam int unsigned StatusOverrunBit = 2;
  localparam int unsigned CtrlIrqEnBit     = 0;

endpackage

// File: rtl/csense_spi_if.sv
// Avalon-MM slave bus plus interrupt for the current-sense SPI master.
interface csense_spi_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, write, writedata, read,
    input  readdata, irq
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, irq
  );
endinterface

// File: rtl/csense_spi_clkgen.sv
// SCLK phase timer: pulses phase_end on the last clk cycle of every CLK_DIV-cycle phase.
module csense_spi_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic phase_end
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign phase_end = enable && (cnt_q == CntMax);

  // Counter restarts each phase and is held at zero while the FSM idles.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || phase_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Phase counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csense_spi_master.sv
// SPI master (mode 0, MSB first) for the current-sense ADC command path, Avalon-MM slave.
// Optional feature: define CSENSE_SDO_CAPTURE_EN to capture csense_sdo into RXDATA.
module csense_spi_master
  import csense_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  csense_spi_if.slave     bus,
  output logic            csense_cs_n,
  output logic            csense_sclk,
  output logic            csense_sdi,
  input  logic            csense_sdo
);

  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  irq_en_q, irq_en_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  sdi_q, sdi_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [31:0]           rxdata_word;
  logic                  phase_end;
  logic                  busy;
  logic                  done_set;
  logic                  txdata_wr, status_wr, control_wr;

  assign busy       = (state_q != StIdle);
  assign txdata_wr  = bus.write && (bus.address == AddrTxdata);
  assign status_wr  = bus.write && (bus.address == AddrStatus);
  assign control_wr = bus.write && (bus.address == AddrControl);

  csense_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (busy),
    .phase_end (phase_end)
  );

  // Frame sequencer; pin values are computed from the next state so the pins come straight
  // from flops.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    done_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (txdata_wr) begin
          tx_d      = bus.writedata[FRAME_BITS-1:0];
          bit_cnt_d = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (phase_end) state_d = StSclkHi;
      end
      StSclkHi: begin
        if (phase_end) begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          tx_d      = tx_q << 1;
          state_d   = StSclkLo;
        end
      end
      StSclkLo: begin
        if (phase_end) state_d = (bit_cnt_q == BitLast) ? StGap : StSclkHi;
      end
      StGap: begin
        if (phase_end) begin
          state_d  = StIdle;
          done_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    cs_n_d = !(state_d inside {StSetup, StSclkHi, StSclkLo});
    sclk_d = (state_d == StSclkHi);
    sdi_d  = cs_n_d ? 1'b0 : tx_d[FRAME_BITS-1];
  end

  // Sticky status bits: a set in the same cycle as a W1C clear wins.
  always_comb begin
    done_d    = done_set |
                (done_q & ~(status_wr & bus.writedata[StatusDoneBit]));
    overrun_d = (txdata_wr & busy) |
                (overrun_q & ~(status_wr & bus.writedata[StatusOverrunBit]));
    irq_en_d  = control_wr ? bus.writedata[CtrlIrqEnBit] : irq_en_q;
  end

  // Read mux, registered every cycle regardless of the read strobe.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      AddrStatus: begin
        readdata_d[StatusBusyBit]    = busy;
        readdata_d[StatusDoneBit]    = done_q;
        readdata_d[StatusOverrunBit] = overrun_q;
      end
      AddrRxdata:  readdata_d = rxdata_word;
      AddrControl: readdata_d[CtrlIrqEnBit] = irq_en_q;
      default:     readdata_d = '0;
    endcase
  end

  // State, shift register and register-file flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      irq_en_q   <= irq_en_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      readdata_q <= readdata_d;
    end
  end

`ifdef CSENSE_SDO_CAPTURE_EN
  logic                  sdo_meta_q, sdo_sync_q;
  logic [FRAME_BITS-1:0] rx_q, rxdata_q;

  // Two-flop synchroniser for the asynchronous ADC return line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdo_meta_q <= 1'b0;
      sdo_sync_q <= 1'b0;
    end else begin
      sdo_meta_q <= csense_sdo;
      sdo_sync_q <= sdo_meta_q;
    end
  end

  // Sample on the last cycle of each high phase; publish to RXDATA when the frame completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q     <= '0;
      rxdata_q <= '0;
    end else begin
      if (!busy && txdata_wr) begin
        rx_q <= '0;
      end else if ((state_q == StSclkHi) && phase_end) begin
        rx_q <= (rx_q << 1) | FRAME_BITS'(sdo_sync_q);
      end
      if (done_set) rxdata_q <= rx_q;
    end
  end

  assign rxdata_word = 32'(rxdata_q);

  logic unused_sigs;
  assign unused_sigs = ^{bus.read, bus.writedata};
`else
  assign rxdata_word = '0;

  logic unused_sigs;
  assign unused_sigs = ^{bus.read, bus.writedata, csense_sdo};
`endif

  assign bus.readdata = readdata_q;
  assign bus.irq      = done_q & irq_en_q;
  assign csense_cs_n  = cs_n_q;
  assign csense_sclk  = sclk_q;
  assign csense_sdi   = sdi_q;

endmodule

// File: tb/tb_csense_spi_master.sv
// Self-checking bench for csense_spi_master: default-parameter instance plus a
// CLK_DIV=1 / FRAME_BITS=1 corner instance. Honours CSENSE_SDO_CAPTURE_EN for RXDATA.
module tb_csense_spi_master;
  import csense_spi_pkg::*;

  localparam int CdA     = 4;
  localparam int FbA     = 16;
  localparam int IdleA   = 1 + 2 * CdA + 2 * CdA * FbA;
  localparam int CsLastA = CdA + 2 * CdA * FbA;
  localparam int MaxCyc  = IdleA + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cs_n_a, sclk_a, sdi_a, sdo_a;
  logic cs_n_b, sclk_b, sdi_b;
  logic sdo_b = 1'b0;

  csense_spi_if bus_a ();
  csense_spi_if bus_b ();

  csense_spi_master #(.CLK_DIV(CdA), .FRAME_BITS(FbA)) u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_a),
    .csense_cs_n (cs_n_a),
    .csense_sclk (sclk_a),
    .csense_sdi  (sdi_a),
    .csense_sdo  (sdo_a)
  );

  csense_spi_master #(.CLK_DIV(1), .FRAME_BITS(1)) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_b),
    .csense_cs_n (cs_n_b),
    .csense_sclk (sclk_b),
    .csense_sdi  (sdi_b),
    .csense_sdo  (sdo_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: mode-0 slave, first bit on CS_n fall, next bit on each SCLK fall.
  logic [15:0] adc_word = 16'h0;
  int adc_idx = FbA - 1;
  always @(negedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a) adc_idx = FbA - 1;
    else adc_idx = adc_idx - 1;
  end
  assign sdo_a = (!cs_n_a && adc_idx >= 0 && adc_idx < FbA) ? adc_word[adc_idx] : 1'b0;

  // Per-cycle record of a frame; index = cycles after the accepting edge.
  logic        cs_s   [0:MaxCyc];
  logic        sclk_s [0:MaxCyc];
  logic        sdi_s  [0:MaxCyc];
  logic        irq_s  [0:MaxCyc];
  logic [31:0] rd_s   [0:MaxCyc];

  task automatic bus_write_a(input logic [1:0] a, input logic [31:0] d);
    bus_a.address = a; bus_a.writedata = d; bus_a.write = 1'b1;
    @(posedge clk); #1;
    bus_a.write = 1'b0; bus_a.address = AddrStatus;
  endtask

  task automatic bus_read_a(input logic [1:0] a, output logic [31:0] v);
    bus_a.address = a;
    @(posedge clk); #1;
    v = bus_a.readdata;
    bus_a.address = AddrStatus;
  endtask

  // mode 0: plain frame; 1: TXDATA write at cycle 10 then STATUS W1C 0x6 at cycle 20;
  // 2: STATUS W1C 0x2 landing on the cycle done sets.
  task automatic frame_a(input logic [15:0] word, input int mode, input logic irq_en);
    int rises, first_rise, cs_first, cs_last, cs_cnt, unstable;
    logic [15:0] got_bits, junk;
    logic [31:0] v, rx_exp;
    bus_write_a(AddrControl, {31'b0, irq_en});
    bus_write_a(AddrStatus, 32'h6);
    junk = 16'($urandom);
    cs_s[0] = cs_n_a; sclk_s[0] = sclk_a; sdi_s[0] = sdi_a; irq_s[0] = bus_a.irq;
    rd_s[0] = bus_a.readdata;
    bus_a.address = AddrTxdata; bus_a.writedata = {junk, word}; bus_a.write = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= MaxCyc; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      cs_s[k] = cs_n_a; sclk_s[k] = sclk_a; sdi_s[k] = sdi_a; irq_s[k] = bus_a.irq;
      rd_s[k] = bus_a.readdata;
      bus_a.write = 1'b0; bus_a.address = AddrStatus;
      if (mode == 1 && k == 9) begin
        bus_a.write = 1'b1; bus_a.address = AddrTxdata; bus_a.writedata = 32'h1234;
      end
      if (mode == 1 && k == 19) begin
        bus_a.write = 1'b1; bus_a.writedata = 32'h6;
      end
      if (mode == 2 && k == IdleA - 1) begin
        bus_a.write = 1'b1; bus_a.writedata = 32'h2;
      end
    end
    bus_a.write = 1'b0;

    rises = 0; first_rise = -1; unstable = 0; got_bits = '0;
    for (int k = 1; k <= MaxCyc; k++) begin
      if (sclk_s[k] && !sclk_s[k-1]) begin
        if (first_rise < 0) first_rise = k;
        got_bits = {got_bits[14:0], sdi_s[k]};
        rises++;
        for (int j = k - CdA; j <= k + CdA - 1; j++) begin
          if (j >= 0 && j <= MaxCyc && sdi_s[j] !== sdi_s[k]) unstable++;
        end
      end
    end
    cs_first = -1; cs_last = -1; cs_cnt = 0;
    for (int k = 0; k <= MaxCyc; k++) begin
      if (!cs_s[k]) begin
        if (cs_first < 0) cs_first = k;
        cs_last = k;
        cs_cnt++;
      end
    end

    check("rise_count", rises, FbA);
    check("tx_bits", 32'(got_bits), 32'(word));
    check("first_rise", first_rise, 1 + CdA);
    check("cs_first", cs_first, 1);
    check("cs_last", cs_last, CsLastA);
    check("cs_len", cs_cnt, CsLastA);
    check("sdi_stable", unstable, 0);
    check("irq_before_done", 32'(irq_s[IdleA-1]), 32'h0);
    check("irq_at_done", 32'(irq_s[IdleA]), 32'(irq_en));
    check("status_last_busy", rd_s[IdleA], 32'h1);
    check("status_after", rd_s[IdleA+1], 32'h2);
    if (mode == 1) begin
      check("status_overrun", rd_s[11], 32'h5);
      check("status_w1c", rd_s[21], 32'h1);
    end else begin
      check("status_mid", rd_s[50], 32'h1);
    end
`ifdef CSENSE_SDO_CAPTURE_EN
    rx_exp = 32'(adc_word);
`else
    rx_exp = 32'h0;
`endif
    bus_read_a(AddrRxdata, v);
    check("rxdata", v, rx_exp);
  endtask

  initial begin
    logic [31:0] v;
    int hi_cnt;
    logic sdi_hi, irq4, irq5, cs1, cs4;
    bus_a.address = AddrStatus; bus_a.write = 1'b0; bus_a.writedata = '0; bus_a.read = 1'b0;
    bus_b.address = AddrStatus; bus_b.write = 1'b0; bus_b.writedata = '0; bus_b.read = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n_a), 32'h1);
    check("rst_sclk", 32'(sclk_a), 32'h0);
    check("rst_sdi", 32'(sdi_a), 32'h0);
    check("rst_readdata", bus_a.readdata, 32'h0);
    check("rst_irq", 32'(bus_a.irq), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    adc_word = 16'h0;
    frame_a(16'hA5C3, 0, 1'b1);
    adc_word = 16'h0F0F;
    frame_a(16'hFFFF, 0, 1'b1);
    adc_word = 16'($urandom);
    frame_a(16'($urandom), 1, 1'b0);
    adc_word = 16'($urandom);
    frame_a(16'($urandom), 2, 1'b1);
    for (int n = 0; n < 6; n++) begin
      adc_word = 16'($urandom);
      frame_a(16'($urandom), 0, 1'($urandom_range(0, 1)));
    end

    // Corner instance: one bit, one-cycle phases.
    for (int n = 0; n < 2; n++) begin
      bus_b.address = AddrControl; bus_b.writedata = 32'h1; bus_b.write = 1'b1;
      @(posedge clk); #1;
      bus_b.address = AddrStatus; bus_b.writedata = 32'h6;
      @(posedge clk); #1;
      bus_b.address = AddrTxdata; bus_b.writedata = (n == 0) ? 32'h1 : 32'hFFFF_FFFE;
      @(posedge clk); #1;
      bus_b.write = 1'b0; bus_b.address = AddrStatus;
      hi_cnt = 0; sdi_hi = 1'b0; irq4 = 1'b1; irq5 = 1'b0; cs1 = 1'b1; cs4 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        if (sclk_b) begin hi_cnt++; sdi_hi = sdi_b; end
        if (k == 1) cs1 = cs_n_b;
        if (k == 4) begin cs4 = cs_n_b; irq4 = bus_b.irq; end
        if (k == 5) irq5 = bus_b.irq;
      end
      check("b_sclk_hi_cycles", hi_cnt, 1);
      check("b_sdi_at_hi", 32'(sdi_hi), (n == 0) ? 32'h1 : 32'h0);
      check("b_cs_low_c1", 32'(cs1), 32'h0);
      check("b_cs_high_c4", 32'(cs4), 32'h1);
      check("b_irq_c4", 32'(irq4), 32'h0);
      check("b_irq_c5", 32'(irq5), 32'h1);
    end

    // Reset mid-frame: done and irq_en are set beforehand so the clear is observable.
    bus_write_a(AddrControl, 32'h1);
    bus_a.address = AddrTxdata; bus_a.writedata = 32'h0000_FFFF; bus_a.write = 1'b1;
    @(posedge clk); #1;
    bus_a.write = 1'b0; bus_a.address = AddrStatus;
    repeat (49) begin @(posedge clk); #1; end
    check("mid_cs_low", 32'(cs_n_a), 32'h0);
    reset_n = 1'b0;
    #1;
    check("mrst_cs_n", 32'(cs_n_a), 32'h1);
    check("mrst_sclk", 32'(sclk_a), 32'h0);
    check("mrst_sdi", 32'(sdi_a), 32'h0);
    check("mrst_irq", 32'(bus_a.irq), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read_a(AddrStatus, v);
    check("mrst_status", v, 32'h0);
    bus_read_a(AddrControl, v);
    check("mrst_control", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
